// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, ciphertext widths and unpacker FSM states
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int DU = 10;
  localparam int DV = 3;
  localparam int DATA_WIDTH = 12;
  localparam int CT0_BITS = KYBER_N * DU;
  localparam int CT1_BITS = KYBER_N * DV;
  localparam int RND_DU = 1 << (DU - 1);
  localparam int RND_DV = 1 << (DV - 1);
  typedef enum logic [2:0] {IDLE, UNPACK_B0, UNPACK_B1, UNPACK_V, FLUSH, DONE} state_t;
endpackage

// File: rtl/state_unpack_cit_if.sv
// state_unpack_cit_if: ciphertext inputs, start/done and Bp/V RAM write ports
interface state_unpack_cit_if;
  import kyber_pkg::*;
  logic enable;
  logic [CT0_BITS-1:0] i_Ciphertext0_0;
  logic [CT0_BITS-1:0] i_Ciphertext0_1;
  logic [CT1_BITS-1:0] i_Ciphertext1;
  logic Unpack_Bp_WEn;
  logic [6:0] Unpack_Bp_WAd;
  logic [4*DATA_WIDTH-1:0] Unpack_Bp_WData;
  logic Unpack_V_WEn;
  logic [4:0] Unpack_V_WAd;
  logic [8*DATA_WIDTH-1:0] Unpack_V_WData;
  logic Function_done;
  modport master(output enable, i_Ciphertext0_0, i_Ciphertext0_1, i_Ciphertext1,
                 input Unpack_Bp_WEn, Unpack_Bp_WAd, Unpack_Bp_WData,
                 Unpack_V_WEn, Unpack_V_WAd, Unpack_V_WData, Function_done);
  modport slave(input enable, i_Ciphertext0_0, i_Ciphertext0_1, i_Ciphertext1,
                output Unpack_Bp_WEn, Unpack_Bp_WAd, Unpack_Bp_WData,
                Unpack_V_WEn, Unpack_V_WAd, Unpack_V_WData, Function_done);
endinterface

// File: rtl/unpack_cit_decompress.sv
// unpack_cit_decompress: per-lane x' = (x*Q + 2^(D-1)) >> D over L packed lanes
module unpack_cit_decompress
  import kyber_pkg::*;
#(
  parameter int D = DU,
  parameter int L = 4,
  parameter int R = RND_DU
) (
  input  logic [D*L-1:0]          x,
  output logic [DATA_WIDTH*L-1:0] y
);
  localparam int W = D + DATA_WIDTH;
  for (genvar i = 0; i < L; i++) begin : g_l
    logic [W-1:0] t;
    assign t = W'(x[D*i +: D]) * W'(KYBER_Q) + W'(R);
    assign y[DATA_WIDTH*i +: DATA_WIDTH] = t[W-1:D];
  end
endmodule

// File: rtl/state_unpack_cit.sv
// state_unpack_cit: decompresses packed ciphertext into Bp/V coefficient RAM words
// Optional UNPACK_CIT_LATCH_EN snapshots the ciphertext inputs at the enable edge.
module state_unpack_cit
  import kyber_pkg::*;
(
  input logic clk,
  input logic rst,
  state_unpack_cit_if.slave bus
);
  state_t st;
  logic [5:0] g, last;
  logic [CT0_BITS-1:0] src0, src1;
  logic [CT1_BITS-1:0] src2;
  logic [11:0] bb;
  logic [9:0] vb;
  logic [39:0] grp, s1_grp;
  logic [6:0] ad, s1_ad;
  logic s1_vld, s1_v, unpacking;
  logic [4*DATA_WIDTH-1:0] bp_y;
  logic [8*DATA_WIDTH-1:0] v_y;
`ifdef UNPACK_CIT_LATCH_EN
  always_ff @(posedge clk)
    if (rst) {src0, src1, src2} <= '0;
    else if (st == IDLE && bus.enable) {src0, src1, src2} <= {bus.i_Ciphertext0_0, bus.i_Ciphertext0_1, bus.i_Ciphertext1};
`else
  assign src0 = bus.i_Ciphertext0_0;
  assign src1 = bus.i_Ciphertext0_1;
  assign src2 = bus.i_Ciphertext1;
`endif
  // Groups are taken MSB-first while addresses descend, mirroring the packer.
  always_comb begin
    unpacking = st == UNPACK_B0 || st == UNPACK_B1 || st == UNPACK_V;
    last = st == UNPACK_V ? 6'd31 : st == FLUSH ? 6'd1 : 6'd63;
    bb = 12'(CT0_BITS - 1 - 40 * int'(g));
    vb = 10'(CT1_BITS - 1 - 24 * int'(g));
    grp = st == UNPACK_B0 ? src0[bb -: 40] : st == UNPACK_B1 ? src1[bb -: 40] : {16'b0, src2[vb -: 24]};
    ad = st == UNPACK_B0 ? 7'd63 - 7'(g) : st == UNPACK_B1 ? 7'd127 - 7'(g) : 7'd31 - 7'(g);
  end
  unpack_cit_decompress #(.D(DU), .L(4), .R(RND_DU)) u_bp (.x(s1_grp), .y(bp_y));
  unpack_cit_decompress #(.D(DV), .L(8), .R(RND_DV)) u_v (.x(s1_grp[23:0]), .y(v_y));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      g <= '0;
      s1_vld <= 1'b0;
      s1_v <= 1'b0;
      s1_grp <= '0;
      s1_ad <= '0;
      bus.Unpack_Bp_WEn <= 1'b0;
      bus.Unpack_Bp_WAd <= '0;
      bus.Unpack_Bp_WData <= '0;
      bus.Unpack_V_WEn <= 1'b0;
      bus.Unpack_V_WAd <= '0;
      bus.Unpack_V_WData <= '0;
      bus.Function_done <= 1'b0;
    end else begin
      s1_vld <= unpacking;
      s1_v <= st == UNPACK_V;
      if (unpacking) begin
        s1_grp <= grp;
        s1_ad <= ad;
      end
      bus.Unpack_Bp_WEn <= s1_vld && !s1_v;
      if (s1_vld && !s1_v) begin
        bus.Unpack_Bp_WAd <= s1_ad;
        bus.Unpack_Bp_WData <= bp_y;
      end
      bus.Unpack_V_WEn <= s1_vld && s1_v;
      if (s1_vld && s1_v) begin
        bus.Unpack_V_WAd <= s1_ad[4:0];
        bus.Unpack_V_WData <= v_y;
      end
      bus.Function_done <= st == FLUSH && g == last;
      if (st == IDLE) begin
        if (bus.enable) st <= UNPACK_B0;
      end else if (st == DONE) begin
        st <= IDLE;
      end else if (g == last) begin
        g <= '0;
        st <= st == UNPACK_B0 ? UNPACK_B1 : st == UNPACK_B1 ? UNPACK_V : st == UNPACK_V ? FLUSH : DONE;
      end else begin
        g <= g + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_state_unpack_cit.sv
// tb_state_unpack_cit: directed checks of write order, timing, data, reset and enable handling
module tb_state_unpack_cit;
  import kyber_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [47:0] exp_bp[128];
  logic [95:0] exp_v[32];
  state_unpack_cit_if bus();
  state_unpack_cit dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      tick;
      chk("idle_bp_wen", 96'(bus.Unpack_Bp_WEn), 96'(0));
      chk("idle_v_wen", 96'(bus.Unpack_V_WEn), 96'(0));
      chk("idle_done", 96'(bus.Function_done), 96'(0));
    end
  endtask

  // Edge N samples enable; cycle N+k is observed 1 time unit after the k-th following edge.
  task automatic run(input bit hold, input bit scramble);
    int bi = 0;
    int vi = 0;
    int ea;
    bus.enable = 1'b1;
    tick;
    bus.enable = hold;
    if (scramble) begin
      for (int i = 0; i < 80; i++) begin
        bus.i_Ciphertext0_0[32*i +: 32] = $urandom();
        bus.i_Ciphertext0_1[32*i +: 32] = $urandom();
      end
      for (int i = 0; i < 24; i++) bus.i_Ciphertext1[32*i +: 32] = $urandom();
    end
    for (int k = 1; k <= 163; k++) begin
      tick;
      if (k == 80 && hold) bus.enable = 1'b0;
      if (k == 81 && hold) bus.enable = 1'b1;
      if (k == 162) bus.enable = 1'b0;
      chk("bp_wen", 96'(bus.Unpack_Bp_WEn), 96'(k >= 2 && k <= 129));
      chk("v_wen", 96'(bus.Unpack_V_WEn), 96'(k >= 130 && k <= 161));
      chk("done", 96'(bus.Function_done), 96'(k == 162));
      if (k >= 2 && k <= 129) begin
        ea = bi < 64 ? 63 - bi : 127 - (bi - 64);
        chk("bp_wad", 96'(bus.Unpack_Bp_WAd), 96'(ea));
        chk("bp_wdata", 96'(bus.Unpack_Bp_WData), 96'(exp_bp[ea]));
        bi++;
      end
      if (k >= 130 && k <= 161) begin
        ea = 31 - vi;
        chk("v_wad", 96'(bus.Unpack_V_WAd), 96'(ea));
        chk("v_wdata", bus.Unpack_V_WData, exp_v[ea]);
        vi++;
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.i_Ciphertext0_0 = '0;
    bus.i_Ciphertext0_1 = '0;
    bus.i_Ciphertext1 = '0;
    for (int i = 0; i < 128; i++) exp_bp[i] = '0;
    for (int i = 0; i < 32; i++) exp_v[i] = '0;
    repeat (3) tick;
    chk("rst_bp_wen", 96'(bus.Unpack_Bp_WEn), 96'(0));
    chk("rst_bp_wad", 96'(bus.Unpack_Bp_WAd), 96'(0));
    chk("rst_bp_wdata", 96'(bus.Unpack_Bp_WData), 96'(0));
    chk("rst_v_wen", 96'(bus.Unpack_V_WEn), 96'(0));
    chk("rst_v_wad", 96'(bus.Unpack_V_WAd), 96'(0));
    chk("rst_v_wdata", bus.Unpack_V_WData, 96'(0));
    chk("rst_done", 96'(bus.Function_done), 96'(0));
    rst = 1'b0;
    idle_check(2);
    // All-zero ciphertext
    run(1'b0, 1'b0);
    chk("hold_bp_wad", 96'(bus.Unpack_Bp_WAd), 96'(64));
    chk("hold_v_wad", 96'(bus.Unpack_V_WAd), 96'(0));
    // Boundary groups: first and last of each polynomial
    bus.i_Ciphertext0_0[2559:2520] = {10'd1023, 10'd512, 10'd1, 10'd0};
    exp_bp[63] = {12'd3326, 12'd1665, 12'd3, 12'd0};
    bus.i_Ciphertext0_1[39:0] = {10'd1023, 10'd1023, 10'd1023, 10'd1023};
    exp_bp[64] = {12'd3326, 12'd3326, 12'd3326, 12'd3326};
    bus.i_Ciphertext0_0[39:0] = {10'd2, 10'd256, 10'd768, 10'd10};
    exp_bp[0] = {12'd7, 12'd832, 12'd2497, 12'd33};
    bus.i_Ciphertext1[767:744] = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_v[31] = {12'd2913, 12'd2497, 12'd2081, 12'd1665, 12'd1248, 12'd832, 12'd416, 12'd0};
    bus.i_Ciphertext1[23:0] = {8{3'd7}};
    exp_v[0] = {8{12'd2913}};
    run(1'b0, 1'b0);
    chk("hold_bp_wdata", 96'(bus.Unpack_Bp_WData), 96'(exp_bp[64]));
    chk("hold_v_wdata", bus.Unpack_V_WData, exp_v[0]);
    // Back-to-back start right after DONE
    run(1'b0, 1'b0);
    // Reset mid-run
    bus.enable = 1'b1;
    tick;
    bus.enable = 1'b0;
    repeat (70) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_bp_wen", 96'(bus.Unpack_Bp_WEn), 96'(0));
    chk("rst_mid_bp_wad", 96'(bus.Unpack_Bp_WAd), 96'(0));
    chk("rst_mid_done", 96'(bus.Function_done), 96'(0));
    idle_check(200);
    run(1'b0, 1'b0);
    // Enable held high with a re-pulse mid-run: single run only
    run(1'b1, 1'b0);
    idle_check(20);
`ifdef UNPACK_CIT_LATCH_EN
    bus.i_Ciphertext0_0 = '0;
    bus.i_Ciphertext0_1 = '0;
    bus.i_Ciphertext1 = '0;
    for (int i = 0; i < 128; i++) exp_bp[i] = '0;
    for (int i = 0; i < 32; i++) exp_v[i] = '0;
    run(1'b0, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
